// File: rtl/banked_memory_pkg.sv
// Shared types, defaults and address decoding for the banked memory.
package banked_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INDIR,
        RESP
    } state_t;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_BANKS      = 4;
    localparam int unsigned DEF_BANK_WORDS = 512;
    localparam logic [15:0] DEF_NOP_WORD   = 16'hD000;

    typedef struct packed {
        logic [15:0] bank;
        logic [15:0] word;
    } addr_dec_t;

    // Byte address -> {bank, word}; bit 0 dropped, both fields wrap by masking.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                              input int unsigned bank_bits,
                                              input int unsigned word_bits);
        logic [31:0] word_mask;
        logic [31:0] bank_mask;
        addr_dec_t   dec;
        word_mask = (32'd1 << word_bits) - 32'd1;
        bank_mask = (32'd1 << bank_bits) - 32'd1;
        dec.word  = 16'((addr >> 1) & word_mask);
        dec.bank  = 16'((addr >> (word_bits + 1)) & bank_mask);
        return dec;
    endfunction

endpackage

// File: rtl/banked_memory_bank.sv
// One memory bank: synchronous write, combinational data and fetch reads.
module mem_bank
    import banked_memory_pkg::*;
#(
    parameter int unsigned         DATA_W   = DEF_DATA_W,
    parameter int unsigned         WORDS    = DEF_BANK_WORDS,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(WORDS)-1:0]  addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    input  logic [$clog2(WORDS)-1:0]  f_addr,
    output logic [DATA_W-1:0]         f_data
);

    // Cells hold value XOR INIT_VAL, so power-up-zero storage reads back as the fill value.
    logic [DATA_W-1:0] cells [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            cells[addr] <= wdata ^ INIT_VAL;
        end
    end

    assign rdata  = cells[addr] ^ INIT_VAL;
    assign f_data = cells[f_addr] ^ INIT_VAL;

endmodule

// File: rtl/banked_memory.sv
// Banked word memory with a data port (direct/indirect, one op at a time) and a non-stalling fetch port.
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       BANKS      = DEF_BANKS,
    parameter int unsigned       BANK_WORDS = DEF_BANK_WORDS,
    parameter logic [DATA_W-1:0] NOP_WORD   = DATA_W'(DEF_NOP_WORD),
    localparam int unsigned      ADDR_W     = $clog2(BANKS) + $clog2(BANK_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_indirect,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data
);

    localparam int unsigned BANK_BITS = $clog2(BANKS);
    localparam int unsigned WORD_BITS = $clog2(BANK_WORDS);

    state_t              state_q;
    state_t              state_d;
    logic                live_q;
    logic [DATA_W-1:0]   ptr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wr_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                if_valid_q;
    logic [DATA_W-1:0]   if_data_q;

    logic                accept;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    addr_dec_t           data_dec;
    addr_dec_t           fetch_dec;
    logic [BANK_BITS-1:0] data_bank;
    logic [WORD_BITS-1:0] data_word;
    logic [BANK_BITS-1:0] fetch_bank;
    logic [WORD_BITS-1:0] fetch_word;
    logic [DATA_W-1:0]   bank_rdata [BANKS];
    logic [DATA_W-1:0]   bank_fdata [BANKS];
    logic [DATA_W-1:0]   data_rd;
    logic [DATA_W-1:0]   fetch_rd;
    logic                unused_dec_bits;

    // The data port addresses the request in IDLE and the captured pointer in INDIR.
    assign data_dec  = decode_addr((state_q == INDIR) ? 32'(ptr_q) : 32'(req_addr),
                                   BANK_BITS, WORD_BITS);
    assign fetch_dec = decode_addr(32'(if_addr), BANK_BITS, WORD_BITS);

    assign data_bank  = data_dec.bank[BANK_BITS-1:0];
    assign data_word  = data_dec.word[WORD_BITS-1:0];
    assign fetch_bank = fetch_dec.bank[BANK_BITS-1:0];
    assign fetch_word = fetch_dec.word[WORD_BITS-1:0];

    assign unused_dec_bits = ^{data_dec.bank[15:BANK_BITS], data_dec.word[15:WORD_BITS],
                               fetch_dec.bank[15:BANK_BITS], fetch_dec.word[15:WORD_BITS]};

    genvar b;
    generate
        for (b = 0; b < BANKS; b++) begin : g_bank
            localparam logic [DATA_W-1:0] FILL = (b == 0) ? NOP_WORD
                                                          : (DATA_W'(b) << (DATA_W - 4));
            mem_bank #(
                .DATA_W   (DATA_W),
                .WORDS    (BANK_WORDS),
                .INIT_VAL (FILL)
            ) u_bank (
                .clk    (clk),
                .we     (mem_we && (data_bank == BANK_BITS'(b))),
                .addr   (data_word),
                .wdata  (mem_wdata),
                .rdata  (bank_rdata[b]),
                .f_addr (fetch_word),
                .f_data (bank_fdata[b])
            );
        end
    endgenerate

    assign data_rd  = bank_rdata[data_bank];
    assign fetch_rd = bank_fdata[fetch_bank];

    assign req_ready  = (state_q == IDLE) && live_q;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign if_valid   = if_valid_q;
    assign if_data    = if_data_q;

    // Write enable is derived from state, so an async reset in INDIR drops the pending write.
    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_wdata = req_wdata;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_indirect) begin
                        state_d = INDIR;
                    end else begin
                        state_d = RESP;
                        mem_we  = req_write;
                    end
                end
            end
            INDIR: begin
                state_d   = RESP;
                mem_we    = wr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            live_q       <= 1'b0;
            ptr_q        <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            resp_rdata_q <= '0;
            if_valid_q   <= 1'b0;
            if_data_q    <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (accept) begin
                if (req_indirect) begin
                    ptr_q   <= data_rd;
                    wdata_q <= req_wdata;
                    wr_q    <= req_write;
                end else begin
                    resp_rdata_q <= req_write ? '0 : data_rd;
                end
            end else if (state_q == INDIR) begin
                resp_rdata_q <= wr_q ? '0 : data_rd;
            end
            if_valid_q <= if_en;
            if (if_en) begin
                if_data_q <= fetch_rd;
            end
        end
    end

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench for banked_memory: flat-array memory model plus per-cycle output comparison.
module tb_banked_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_indirect;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        if_en;
    logic [11:0] if_addr;
    logic        if_valid;
    logic [15:0] if_data;

    banked_memory #(
        .DATA_W     (16),
        .BANKS      (4),
        .BANK_WORDS (512),
        .NOP_WORD   (16'hD000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_indirect (req_indirect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .if_en        (if_en),
        .if_addr      (if_addr),
        .if_valid     (if_valid),
        .if_data      (if_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: 2048 words addressed by byte address bits [11:1] (bank*512 + word).
    logic [15:0] mm [2048];
    logic        pend_we = 1'b0;
    int          pend_idx = 0;
    logic [15:0] pend_data = '0;

    logic        chk_en = 1'b0;
    logic        exp_req_ready = 1'b0;
    logic        exp_resp_valid = 1'b0;
    logic        exp_rdata_chk = 1'b1;
    logic [15:0] exp_rdata = '0;
    logic        exp_if_valid = 1'b0;
    logic [15:0] exp_if_data = '0;

    function automatic int idx(input logic [11:0] a);
        return int'(a[11:1]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_req_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_resp_valid));
            if (exp_rdata_chk) check("resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
            check("if_valid", 32'(if_valid), 32'(exp_if_valid));
            check("if_data", 32'(if_data), 32'(exp_if_data));
        end
    end

    // One clock: fetch sees memory before this edge's write; pending model write lands after.
    task automatic tick();
        logic        fv;
        logic [15:0] fd;
        fv = rst ? 1'b0 : if_en;
        fd = rst ? 16'h0000 : (if_en ? mm[idx(if_addr)] : exp_if_data);
        @(posedge clk);
        if (pend_we && !rst) mm[pend_idx] = pend_data;
        pend_we = 1'b0;
        exp_if_valid = fv;
        exp_if_data  = fd;
        #1;
    endtask

    task automatic do_op(input logic wr, input logic ind, input logic [11:0] addr,
                         input logic [15:0] wd, input int unsigned hold,
                         output logic [15:0] got, output logic [15:0] if_after);
        int          tgt;
        logic [15:0] ptr;
        logic [15:0] res;
        ptr = mm[idx(addr)];
        tgt = ind ? idx(ptr[11:0]) : idx(addr);
        res = wr ? 16'h0000 : mm[tgt];
        req_valid = 1'b1; req_write = wr; req_indirect = ind;
        req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
        if (wr && !ind) begin pend_we = 1'b1; pend_idx = tgt; pend_data = wd; end
        tick();
        if_after = if_data;
        req_valid = 1'b0; req_write = 1'b0; req_indirect = 1'b0; req_wdata = 16'h5A5A;
        exp_req_ready = 1'b0;
        if (ind) begin
            if (wr) begin pend_we = 1'b1; pend_idx = tgt; pend_data = wd; end
            tick();
        end
        exp_resp_valid = 1'b1; exp_rdata = res; exp_rdata_chk = 1'b1;
        for (int unsigned i = 0; i < hold; i++) begin
            // A write request offered while a response is pending must be ignored.
            req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h460; req_wdata = 16'hDEAD;
            tick();
        end
        req_valid = 1'b0; req_write = 1'b0;
        got = resp_rdata;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        exp_resp_valid = 1'b0; exp_rdata_chk = 1'b0; exp_req_ready = 1'b1;
    endtask

    logic [15:0] got;
    logic [15:0] fa;
    logic [11:0] sweep [6] = '{12'h000, 12'h402, 12'h802, 12'hC00, 12'h460, 12'h7FE};

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mm[i] = (i / 512 == 0) ? 16'hD000 : 16'((i / 512) << 12);
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_indirect = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; if_en = 1'b0; if_addr = '0;
        tick(); tick();
        chk_en = 1'b1;
        if_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_req_ready = 1'b1; exp_rdata_chk = 1'b0;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        if_en = 1'b0;

        do_op(1'b0, 1'b0, 12'h412, 16'h0000, 0, got, fa);
        check("direct_read_412", 32'(got), 32'h1000);
        do_op(1'b0, 1'b0, 12'h413, 16'h0000, 0, got, fa);
        check("bit0_ignored", 32'(got), 32'h1000);

        do_op(1'b1, 1'b0, 12'h460, 16'h07FE, 0, got, fa);
        check("write_ack_zero", 32'(got), 32'h0000);
        do_op(1'b1, 1'b0, 12'h002, 16'h0460, 0, got, fa);
        do_op(1'b0, 1'b1, 12'h002, 16'h0000, 0, got, fa);
        check("indirect_read", 32'(got), 32'h07FE);

        do_op(1'b0, 1'b0, 12'h460, 16'h0000, 5, got, fa);
        check("held_resp", 32'(got), 32'h07FE);
        do_op(1'b0, 1'b0, 12'h460, 16'h0000, 0, got, fa);
        check("ignored_write", 32'(got), 32'h07FE);

        do_op(1'b1, 1'b0, 12'h004, 16'h0C00, 0, got, fa);
        do_op(1'b1, 1'b1, 12'h004, 16'hBEEF, 0, got, fa);
        check("indirect_write_ack", 32'(got), 32'h0000);
        do_op(1'b0, 1'b0, 12'hC00, 16'h0000, 0, got, fa);
        check("indirect_target", 32'(got), 32'hBEEF);
        do_op(1'b0, 1'b0, 12'h004, 16'h0000, 0, got, fa);
        check("pointer_unchanged", 32'(got), 32'h0C00);

        if_en = 1'b1; if_addr = 12'h010;
        do_op(1'b1, 1'b0, 12'h010, 16'h1357, 0, got, fa);
        check("fetch_rbw_old", 32'(fa), 32'hD000);
        check("fetch_new", 32'(if_data), 32'h1357);
        if_en = 1'b0;
        tick();
        check("fetch_hold_data", 32'(if_data), 32'h1357);
        check("fetch_off_valid", 32'(if_valid), 32'd0);

        do_op(1'b1, 1'b0, 12'h008, 16'hF412, 0, got, fa);
        do_op(1'b0, 1'b1, 12'h008, 16'h0000, 0, got, fa);
        check("ptr_wrap", 32'(got), 32'h1000);

        for (int i = 0; i < 6; i++) begin
            if_addr = sweep[i];
            if_en = (i % 3 != 2);
            tick();
        end
        if_en = 1'b0;

        // Reset while an indirect write is waiting in INDIR.
        do_op(1'b1, 1'b0, 12'h006, 16'h0802, 0, got, fa);
        req_valid = 1'b1; req_write = 1'b1; req_indirect = 1'b1;
        req_addr = 12'h006; req_wdata = 16'h1234;
        tick();
        req_valid = 1'b0; req_write = 1'b0; req_indirect = 1'b0;
        exp_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        exp_resp_valid = 1'b0; exp_rdata = 16'h0000; exp_rdata_chk = 1'b1;
        exp_if_valid = 1'b0; exp_if_data = 16'h0000;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        exp_req_ready = 1'b1; exp_rdata_chk = 1'b0;
        check("ready_after_pulse", 32'(req_ready), 32'd1);
        do_op(1'b0, 1'b0, 12'h802, 16'h0000, 0, got, fa);
        check("discarded_write", 32'(got), 32'h2000);

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
